fetch_stage: RTL and testbench

//  Instruction-fetch stage: holds the PC, selects the next PC from the pcSrc/Kill decision made in decode,

---
 rtl/pipeline_defs.sv | 17 +
 rtl/fetch_stage_if.sv | 39 +++
 rtl/if_id_reg.sv | 46 ++++
 rtl/fetch_stage.sv | 84 ++++++++
 tb/tb_fetch_stage.sv | 135 +++++++++++++
 5 files changed

// File: rtl/pipeline_defs.sv
// Shared pipeline definitions: default datapath widths, the NOP encoding and the pcSrc codes
// used by every stage.
package pipeline_defs;

    localparam int PC_W_DEF    = 16;
    localparam int INSTR_W_DEF = 16;

    localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'b00,
        PCSRC_JMP = 2'b01,
        PCSRC_JR  = 2'b10,
        PCSRC_RSV = 2'b11
    } pcsrc_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: redirect/stall controls, instruction-memory port and IF/ID outputs.
// The perf counters exist only when FETCH_PERF_CNT_EN is defined.
interface fetch_stage_if #(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 16
);
    logic [1:0]         pcSrc;
    logic               Kill;
    logic               stall;
    logic [PC_W-1:0]    jump_target;
    logic [PC_W-1:0]    jr_target;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               if_id_valid;
    logic [INSTR_W-1:0] if_id_instr;
    logic [PC_W-1:0]    if_id_pc;
    logic [PC_W-1:0]    if_id_pc_plus1;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]        fetched_cnt;
    logic [31:0]        killed_cnt;
`endif

    modport master (
        input  pcSrc, Kill, stall, jump_target, jr_target, imem_rdata,
        output imem_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus1
`ifdef FETCH_PERF_CNT_EN
        , output fetched_cnt, killed_cnt
`endif
    );

    modport slave (
        output pcSrc, Kill, stall, jump_target, jr_target, imem_rdata,
        input  imem_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus1
`ifdef FETCH_PERF_CNT_EN
        , input fetched_cnt, killed_cnt
`endif
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Flush inserts a bubble and overrides hold; load captures the
// fetched word; otherwise the entry holds.
module if_id_reg
    import pipeline_defs::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               load,
    input  logic [INSTR_W-1:0] fetch_instr,
    input  logic [PC_W-1:0]    fetch_pc,
    input  logic [PC_W-1:0]    fetch_pc_plus1,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    pc_plus1
);

    logic               valid_reg;
    logic [INSTR_W-1:0] instr_reg;
    logic [PC_W-1:0]    pc_reg;
    logic [PC_W-1:0]    pc_plus1_reg;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            valid_reg    <= 1'b0;
            instr_reg    <= INSTR_W'(NOP_INSTR);
            pc_reg       <= '0;
            pc_plus1_reg <= '0;
        end else if (load) begin
            valid_reg    <= 1'b1;
            instr_reg    <= fetch_instr;
            pc_reg       <= fetch_pc;
            pc_plus1_reg <= fetch_pc_plus1;
        end
    end

    assign valid    = valid_reg;
    assign instr    = instr_reg;
    assign pc       = pc_reg;
    assign pc_plus1 = pc_plus1_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC mux and IF/ID capture.
// Define FETCH_PERF_CNT_EN to add saturating fetched/killed counters.
module fetch_stage
    import pipeline_defs::*;
#(
    parameter int          PC_W     = PC_W_DEF,
    parameter int          INSTR_W  = INSTR_W_DEF,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);

    logic [PC_W-1:0] pc_reg;
    logic [PC_W-1:0] pc_plus1;
    logic [PC_W-1:0] pc_next;
    logic            advance;
    logic            load_entry;

    assign pc_plus1   = pc_reg + PC_W'(1);
    assign advance    = bus.Kill || !bus.stall;
    assign load_entry = !bus.Kill && !bus.stall;

    // Redirect targets are honoured only together with Kill; otherwise fall through sequentially.
    always_comb begin
        pc_next = pc_plus1;
        if (bus.Kill) begin
            case (pcsrc_e'(bus.pcSrc))
                PCSRC_JMP: pc_next = bus.jump_target;
                PCSRC_JR:  pc_next = bus.jr_target;
                PCSRC_SEQ,
                PCSRC_RSV: pc_next = pc_plus1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            pc_reg <= PC_W'(RESET_PC);
        else if (advance)
            pc_reg <= pc_next;
    end

    assign bus.imem_addr = pc_reg;

    if_id_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_if_id_reg (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (bus.Kill),
        .load           (load_entry),
        .fetch_instr    (bus.imem_rdata),
        .fetch_pc       (pc_reg),
        .fetch_pc_plus1 (pc_plus1),
        .valid          (bus.if_id_valid),
        .instr          (bus.if_id_instr),
        .pc             (bus.if_id_pc),
        .pc_plus1       (bus.if_id_pc_plus1)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_cnt_reg;
    logic [31:0] killed_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetched_cnt_reg <= '0;
            killed_cnt_reg  <= '0;
        end else begin
            if (load_entry && fetched_cnt_reg != 32'hFFFF_FFFF)
                fetched_cnt_reg <= fetched_cnt_reg + 32'd1;
            if (bus.Kill && killed_cnt_reg != 32'hFFFF_FFFF)
                killed_cnt_reg <= killed_cnt_reg + 32'd1;
        end
    end

    assign bus.fetched_cnt = fetched_cnt_reg;
    assign bus.killed_cnt  = killed_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a per-edge vector table plus a counter sequence when
// FETCH_PERF_CNT_EN is defined. Instruction memory returns addr+'h100.
module tb_fetch_stage;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    fetch_stage_if #(.PC_W(16), .INSTR_W(16)) bus ();

    fetch_stage #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.imem_rdata = bus.imem_addr + 16'h0100;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [1:0]  pc_src;
        logic        kill;
        logic        stall;
        logic [15:0] jt;
        logic [15:0] jrt;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_instr;
        logic [15:0] e_pc;
        logic [15:0] e_pp1;
    } vec_t;

    localparam int NVEC = 22;
    vec_t tbl [NVEC];

    function automatic vec_t mk(logic r, logic [1:0] s, logic k, logic st, logic [15:0] jt,
                                logic [15:0] jrt, logic [15:0] a, logic v, logic [15:0] ins,
                                logic [15:0] p, logic [15:0] pp1);
        vec_t t;
        t.rst_n = r; t.pc_src = s; t.kill = k; t.stall = st; t.jt = jt; t.jrt = jrt;
        t.e_addr = a; t.e_valid = v; t.e_instr = ins; t.e_pc = p; t.e_pp1 = pp1;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%h expected=%h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] s, input logic k, input logic st,
                         input logic [15:0] jt, input logic [15:0] jrt);
        rst_n = r; bus.pcSrc = s; bus.Kill = k; bus.stall = st;
        bus.jump_target = jt; bus.jr_target = jrt;
    endtask

    initial begin
        //                r  src  K  S  jt      jrt      addr     v  instr    pc       pc+1
        tbl[0]  = mk(0, 2'b00, 0, 0, 16'h0, 16'h0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000);
        tbl[1]  = mk(0, 2'b00, 0, 0, 16'h0, 16'h0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000);
        tbl[2]  = mk(1, 2'b00, 0, 0, 16'h0, 16'h0, 16'h0001, 1, 16'h0100, 16'h0000, 16'h0001);
        tbl[3]  = mk(1, 2'b00, 0, 0, 16'h0, 16'h0, 16'h0002, 1, 16'h0101, 16'h0001, 16'h0002);
        tbl[4]  = mk(1, 2'b00, 0, 0, 16'h0, 16'h0, 16'h0003, 1, 16'h0102, 16'h0002, 16'h0003);
        tbl[5]  = mk(1, 2'b00, 0, 0, 16'h0, 16'h0, 16'h0004, 1, 16'h0103, 16'h0003, 16'h0004);
        tbl[6]  = mk(1, 2'b00, 0, 0, 16'h0, 16'h0, 16'h0005, 1, 16'h0104, 16'h0004, 16'h0005);
        // jump from PC=5 to 'h20: one bubble, then the target instruction
        tbl[7]  = mk(1, 2'b01, 1, 0, 16'h20, 16'h0, 16'h0020, 0, 16'h0000, 16'h0000, 16'h0000);
        tbl[8]  = mk(1, 2'b00, 0, 0, 16'h0, 16'h0, 16'h0021, 1, 16'h0120, 16'h0020, 16'h0021);
        // Kill beats stall on a JR redirect
        tbl[9]  = mk(1, 2'b10, 1, 1, 16'h0, 16'h40, 16'h0040, 0, 16'h0000, 16'h0000, 16'h0000);
        tbl[10] = mk(1, 2'b00, 0, 0, 16'h0, 16'h0, 16'h0041, 1, 16'h0140, 16'h0040, 16'h0041);
        tbl[11] = mk(1, 2'b00, 0, 1, 16'h0, 16'h0, 16'h0041, 1, 16'h0140, 16'h0040, 16'h0041);
        tbl[12] = mk(1, 2'b01, 0, 1, 16'h99, 16'h0, 16'h0041, 1, 16'h0140, 16'h0040, 16'h0041);
        tbl[13] = mk(1, 2'b00, 0, 1, 16'h0, 16'h0, 16'h0041, 1, 16'h0140, 16'h0040, 16'h0041);
        tbl[14] = mk(1, 2'b00, 0, 0, 16'h0, 16'h0, 16'h0042, 1, 16'h0141, 16'h0041, 16'h0042);
        // reach 'hFFFF, then wrap with the reserved pcSrc code
        tbl[15] = mk(1, 2'b01, 1, 0, 16'hFFFF, 16'h0, 16'hFFFF, 0, 16'h0000, 16'h0000, 16'h0000);
        tbl[16] = mk(1, 2'b11, 0, 0, 16'h0, 16'h0, 16'h0000, 1, 16'h00FF, 16'hFFFF, 16'h0000);
        tbl[17] = mk(1, 2'b01, 0, 0, 16'h77, 16'h0, 16'h0001, 1, 16'h0100, 16'h0000, 16'h0001);
        tbl[18] = mk(1, 2'b10, 0, 0, 16'h0, 16'h55, 16'h0002, 1, 16'h0101, 16'h0001, 16'h0002);
        // reset overrides a pending redirect and a stall
        tbl[19] = mk(0, 2'b01, 1, 0, 16'h30, 16'h0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000);
        tbl[20] = mk(0, 2'b00, 0, 1, 16'h0, 16'h0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000);
        tbl[21] = mk(1, 2'b00, 0, 0, 16'h0, 16'h0, 16'h0001, 1, 16'h0100, 16'h0000, 16'h0001);

        drive(0, 2'b00, 0, 0, 16'h0, 16'h0);
        @(posedge clk); #1;

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].rst_n, tbl[i].pc_src, tbl[i].kill, tbl[i].stall, tbl[i].jt, tbl[i].jrt);
            @(posedge clk); #1;
            chk("imem_addr",   i, 32'(bus.imem_addr),      32'(tbl[i].e_addr));
            chk("if_id_valid", i, 32'(bus.if_id_valid),    32'(tbl[i].e_valid));
            chk("if_id_instr", i, 32'(bus.if_id_instr),    32'(tbl[i].e_instr));
            chk("if_id_pc",    i, 32'(bus.if_id_pc),       32'(tbl[i].e_pc));
            chk("if_id_pc_p1", i, 32'(bus.if_id_pc_plus1), 32'(tbl[i].e_pp1));
            $display("vec %0d: rst_n=%0b src=%0d kill=%0b stall=%0b -> addr=%h v=%0b instr=%h pc=%h",
                     i, tbl[i].rst_n, tbl[i].pc_src, tbl[i].kill, tbl[i].stall,
                     bus.imem_addr, bus.if_id_valid, bus.if_id_instr, bus.if_id_pc);
        end

`ifdef FETCH_PERF_CNT_EN
        drive(0, 2'b00, 0, 0, 16'h0, 16'h0);
        @(posedge clk); #1;
        chk("fetched_rst", 100, bus.fetched_cnt, 32'd0);
        chk("killed_rst",  100, bus.killed_cnt,  32'd0);
        for (int i = 0; i < 10; i++) begin
            if (i == 3 || i == 7) drive(1, 2'b01, 1, 0, 16'h10, 16'h0);
            else                  drive(1, 2'b00, 0, 0, 16'h0, 16'h0);
            @(posedge clk); #1;
            $display("cnt edge %0d: fetched=%0d killed=%0d", i, bus.fetched_cnt, bus.killed_cnt);
        end
        chk("fetched_cnt", 101, bus.fetched_cnt, 32'd8);
        chk("killed_cnt",  101, bus.killed_cnt,  32'd2);
        drive(1, 2'b00, 0, 1, 16'h0, 16'h0);
        @(posedge clk); #1;
        chk("fetched_stall", 102, bus.fetched_cnt, 32'd8);
        drive(0, 2'b01, 1, 0, 16'h10, 16'h0);
        @(posedge clk); #1;
        chk("fetched_clr", 103, bus.fetched_cnt, 32'd0);
        chk("killed_clr",  103, bus.killed_cnt,  32'd0);
        chk("pc_clr",      103, 32'(bus.imem_addr), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
